buff_sched: RTL and testbench
=============================

# buff_sched

Request scheduler in front of the multi-FIFO static buffer. Takes push/pop requests over valid/ready handshakes and keeps a shadow occupancy count per FIFO. Issues a push or pop to the buffer only when that operation is legal (no overflow, no underflow). Also produces a read-response tag (valid + FIFO index), delayed to line up with the buffer's pop data output.

## Interface
Parameters:
- NUMELEM, 4, entries per FIFO (BITELEM = $clog2(NUMELEM))
- BITDATA, 4, data width
- NUMFIFO, 8, number of FIFOs (BITFIFO = $clog2(NUMFIFO))
- POP_DELAY, 2, cycles from buffer pop to buffer data out (DAT_DELAY+QPT_DELAY of the buffer); must be ≥1

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- buf_ready  in  1  buffer initialisation complete
- in_push_vld  in  1  push request
- in_push_prt  in  BITFIFO  push target FIFO
- in_push_din  in  BITDATA  push data
- in_push_rdy  out  1  push accepted when vld&&rdy
- in_pop_vld  in  1  pop request
- in_pop_prt  in  BITFIFO  pop target FIFO
- in_pop_rdy  out  1  pop accepted when vld&&rdy
- push  out  1  buffer push strobe
- pu_prt  out  BITFIFO  buffer push FIFO index
- pu_din  out  BITDATA  buffer push data
- pop  out  1  buffer pop strobe
- po_prt  out  BITFIFO  buffer pop FIFO index
- rsp_vld  out  1  buffer po_dout is valid this cycle
- rsp_prt  out  BITFIFO  FIFO index that the current po_dout came from
- full  out  NUMFIFO  bit i = FIFO i holds NUMELEM entries
- empty  out  NUMFIFO  bit i = FIFO i holds 0 entries

## Operation
- State machine: WAIT, RUN.
  - rst forces WAIT.
  - WAIT→RUN on the first clk edge where buf_ready=1.
  - RUN is left only by rst.
- Counts: cnt[i], width BITELEM+1, one per FIFO, all cleared to 0 on rst.
- in_push_rdy = RUN && buf_ready && in_push_prt<NUMFIFO && cnt[in_push_prt]<NUMELEM.
  - Combinational; must not depend on in_push_vld.
- in_pop_rdy = RUN && buf_ready && in_pop_prt<NUMFIFO && cnt[in_pop_prt]>0.
  - Combinational; must not depend on in_pop_vld.
- Legality is always judged on the pre-cycle count.
  - A push to a full FIFO is refused even if a pop to the same FIFO is accepted in the same cycle.
  - A pop from an empty FIFO is refused even if a push to it is accepted in the same cycle.
- Accepted push:
  - push=1, pu_prt=in_push_prt, pu_din=in_push_din in the same cycle (combinational pass-through).
  - cnt[prt] increments at the next edge.
- Accepted pop:
  - pop=1, po_prt=in_pop_prt in the same cycle.
  - cnt[prt] decrements at the next edge.
- Push and pop accepted to the same FIFO in one cycle: cnt is unchanged.
- Push and pop accepted to different FIFOs: each count updates independently.
- Counts are never allowed to go below 0 or above NUMELEM.
- full/empty are decoded from the registered cnt.
  - Reset values: full=0, empty=all ones.
- If buf_ready drops while in RUN, both rdy outputs go low; counts are held.

## Timing
- Request to buffer strobe: 0 cycles, combinational.
- Count and full/empty update: 1 cycle after acceptance.
- Response path:
  - rsp_vld/rsp_prt are {pop, po_prt} delayed by exactly POP_DELAY registered stages.
  - Therefore rsp_vld=1 in cycle t+POP_DELAY for a pop accepted in cycle t.
- Back-to-back accepted pops produce back-to-back rsp_vld, in request order.
- Reset values:
  - Registered: all rsp stages clear (rsp_vld=0, rsp_prt=0), state=WAIT.
  - Combinational: push=0, pop=0, in_push_rdy=0, in_pop_rdy=0.
- Reset mid-operation:
  - Responses in flight are discarded; rsp_vld=0 from the cycle after the rst edge.
  - All counts return to 0.
  - Requests are refused until buf_ready is seen again.

## Test plan
- Reset, buf_ready held 0 for 5 cycles, then 1:
  - rdy stays 0 through the WAIT cycles.
  - rdy=1 one cycle after buf_ready is sampled high.
  - Pops to any FIFO are refused (empty=8'hFF).
- Push FIFO 3 data 4'hA..4'hD on 4 consecutive cycles:
  - push pass-through matches each request.
  - cnt[3]=4 and full[3]=1 after the 4th.
  - 5th push to FIFO 3 has in_push_rdy=0 and push=0.
- With FIFO 3 full, push and pop to FIFO 3 in the same cycle:
  - Pop accepted, push refused; cnt[3]=3.
  - Next cycle the push is accepted; cnt[3]=4.
- With FIFO 2 holding 1 entry, push FIFO 2 and pop FIFO 2 in the same cycle:
  - Both accepted; cnt[2] stays 1.
  - rsp_vld=1 with rsp_prt=2 exactly POP_DELAY cycles later.
- Pops to FIFOs 1, 5, 1 on consecutive cycles (each non-empty):
  - rsp_prt sequence 1, 5, 1 starting at t+POP_DELAY, with no gaps.
- Assert rst one cycle after a pop:
  - rsp_vld never rises for that pop.
  - All counts read 0 (empty=8'hFF).
  - rdy stays 0 until buf_ready is seen again.

Source files
------------

// File: rtl/buff_sched_if.sv
// Request/strobe bundle between requesters, the scheduler and the buffer.
// master drives requests; slave is the scheduler.
interface buff_sched_if #(
    parameter int BITDATA = 4,
    parameter int NUMFIFO = 8
);
    localparam int BITFIFO = $clog2(NUMFIFO);

    logic               buf_ready;
    logic               in_push_vld;
    logic [BITFIFO-1:0] in_push_prt;
    logic [BITDATA-1:0] in_push_din;
    logic               in_push_rdy;
    logic               in_pop_vld;
    logic [BITFIFO-1:0] in_pop_prt;
    logic               in_pop_rdy;
    logic               push;
    logic [BITFIFO-1:0] pu_prt;
    logic [BITDATA-1:0] pu_din;
    logic               pop;
    logic [BITFIFO-1:0] po_prt;
    logic               rsp_vld;
    logic [BITFIFO-1:0] rsp_prt;
    logic [NUMFIFO-1:0] full;
    logic [NUMFIFO-1:0] empty;

    modport master (
        output buf_ready, in_push_vld, in_push_prt, in_push_din,
        output in_pop_vld, in_pop_prt,
        input  in_push_rdy, in_pop_rdy, push, pu_prt, pu_din,
        input  pop, po_prt, rsp_vld, rsp_prt, full, empty
    );

    modport slave (
        input  buf_ready, in_push_vld, in_push_prt, in_push_din,
        input  in_pop_vld, in_pop_prt,
        output in_push_rdy, in_pop_rdy, push, pu_prt, pu_din,
        output pop, po_prt, rsp_vld, rsp_prt, full, empty
    );
endinterface

// File: rtl/buff_sched.sv
// Push/pop scheduler for the multi-FIFO buffer: shadow counts gate
// illegal ops; pop tags are delayed to meet the buffer's data out.
module buff_sched #(
    parameter int NUMELEM   = 4,
    parameter int BITDATA   = 4,
    parameter int NUMFIFO   = 8,
    parameter int POP_DELAY = 2
) (
    input  logic        clk,
    input  logic        rst,
    buff_sched_if.slave bus
);
    localparam int BITELEM = $clog2(NUMELEM);
    localparam int BITFIFO = $clog2(NUMFIFO);
    localparam logic [BITELEM:0] CNT_MAX = (BITELEM+1)'(NUMELEM);
    localparam logic [BITFIFO:0] PRT_LIM = (BITFIFO+1)'(NUMFIFO);

    typedef enum logic {WAIT, RUN} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [BITELEM:0]   cnt [NUMFIFO];
    logic [BITELEM:0]   push_cnt;
    logic [BITELEM:0]   pop_cnt;
    logic [BITFIFO:0]   push_ix;
    logic [BITFIFO:0]   pop_ix;
    logic               push_ok;
    logic               pop_ok;
    logic [NUMFIFO-1:0] inc;
    logic [NUMFIFO-1:0] dec;
    logic               rsp_v [POP_DELAY];
    logic [BITFIFO-1:0] rsp_p [POP_DELAY];

    always_ff @(posedge clk) begin
        if (rst) state <= WAIT;
        else     state <= state_nxt;
    end

    // Legality is judged on the registered (pre-cycle) count only.
    assign push_ix  = {1'b0, bus.in_push_prt};
    assign pop_ix   = {1'b0, bus.in_pop_prt};
    assign push_cnt = cnt[bus.in_push_prt];
    assign pop_cnt  = cnt[bus.in_pop_prt];
    assign push_ok  = (push_ix < PRT_LIM) && (push_cnt < CNT_MAX);
    assign pop_ok   = (pop_ix < PRT_LIM) && (pop_cnt != '0);

    always_comb begin
        state_nxt       = state;
        bus.in_push_rdy = 1'b0;
        bus.in_pop_rdy  = 1'b0;
        unique case (state)
            WAIT: if (bus.buf_ready) state_nxt = RUN;
            RUN: begin
                bus.in_push_rdy = bus.buf_ready && push_ok;
                bus.in_pop_rdy  = bus.buf_ready && pop_ok;
            end
        endcase
    end

    assign bus.push   = bus.in_push_vld && bus.in_push_rdy;
    assign bus.pu_prt = bus.in_push_prt;
    assign bus.pu_din = bus.in_push_din;
    assign bus.pop    = bus.in_pop_vld && bus.in_pop_rdy;
    assign bus.po_prt = bus.in_pop_prt;

    always_comb begin
        inc = '0;
        dec = '0;
        if (bus.push) inc[bus.pu_prt] = 1'b1;
        if (bus.pop)  dec[bus.po_prt] = 1'b1;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUMFIFO; i++) begin
            if (rst)                    cnt[i] <= '0;
            else if (inc[i] && !dec[i]) cnt[i] <= cnt[i] + 1'b1;
            else if (dec[i] && !inc[i]) cnt[i] <= cnt[i] - 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < NUMFIFO; i++) begin
            bus.full[i]  = (cnt[i] == CNT_MAX);
            bus.empty[i] = (cnt[i] == '0);
        end
    end

    // Tag pipeline mirrors the buffer's pop-to-data latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < POP_DELAY; i++) begin
                rsp_v[i] <= 1'b0;
                rsp_p[i] <= '0;
            end
        end else begin
            rsp_v[0] <= bus.pop;
            rsp_p[0] <= bus.po_prt;
            for (int i = 1; i < POP_DELAY; i++) begin
                rsp_v[i] <= rsp_v[i-1];
                rsp_p[i] <= rsp_p[i-1];
            end
        end
    end

    assign bus.rsp_vld = rsp_v[POP_DELAY-1];
    assign bus.rsp_prt = rsp_p[POP_DELAY-1];
endmodule

// File: tb/tb_buff_sched.sv
// Randomised scoreboard bench for buff_sched: occupancy model plus
// a queue of expected response tags keyed by due cycle.
module tb_buff_sched;
    localparam int NE = 4;
    localparam int BD = 4;
    localparam int NF = 8;
    localparam int PD = 2;

    typedef struct {
        int due;
        int prt;
    } rsp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    int   mcnt [NF];
    bit   mrun = 1'b0;
    bit   mvalid = 1'b0;
    rsp_t expq [$];

    buff_sched_if #(.BITDATA(BD), .NUMFIFO(NF)) bus ();

    buff_sched #(
        .NUMELEM(NE), .BITDATA(BD), .NUMFIFO(NF), .POP_DELAY(PD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic drive(input bit pv, input int pp, input int pd,
                         input bit ov, input int op);
        bus.in_push_vld = pv;
        bus.in_push_prt = 3'(pp);
        bus.in_push_din = 4'(pd);
        bus.in_pop_vld  = ov;
        bus.in_pop_prt  = 3'(op);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every rsp_vld pops one expected tag.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (bus.rsp_vld) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got prt %0d want none at cycle %0d",
                             bus.rsp_prt, cyc);
                end else begin
                    e = expq.pop_front();
                    chk("rsp_due", cyc, e.due);
                    chk("rsp_prt", bus.rsp_prt, e.prt);
                end
            end else if (expq.size() > 0 && expq[0].due <= cyc) begin
                e = expq.pop_front();
                checks++;
                errors++;
                $display("FAIL rsp_missing: got none want prt %0d at cycle %0d", e.prt, cyc);
            end
        end
    end

    // Reference model: occupancy per FIFO, judged on pre-cycle counts.
    initial begin
        bit ep, eo, pv, ov;
        int pp, op;
        logic [NF-1:0] ef, ee;
        forever begin
            @(negedge clk);
            #1;
            if (!mvalid) begin
                if (rst === 1'b1) begin
                    mvalid = 1'b1;
                    mrun = 1'b0;
                    foreach (mcnt[i]) mcnt[i] = 0;
                end
                continue;
            end
            pv = bus.in_push_vld;
            ov = bus.in_pop_vld;
            pp = int'(bus.in_push_prt);
            op = int'(bus.in_pop_prt);
            ep = mrun && bus.buf_ready && (mcnt[pp] < NE);
            eo = mrun && bus.buf_ready && (mcnt[op] > 0);
            chk("push_rdy", bus.in_push_rdy, ep);
            chk("pop_rdy", bus.in_pop_rdy, eo);
            chk("push", bus.push, ep && pv);
            chk("pop", bus.pop, eo && ov);
            if (ep && pv) begin
                chk("pu_prt", bus.pu_prt, pp);
                chk("pu_din", bus.pu_din, bus.in_push_din);
            end
            if (eo && ov) chk("po_prt", bus.po_prt, op);
            for (int i = 0; i < NF; i++) begin
                ef[i] = (mcnt[i] == NE);
                ee[i] = (mcnt[i] == 0);
            end
            chk("full", bus.full, ef);
            chk("empty", bus.empty, ee);
            if (rst) begin
                mrun = 1'b0;
                foreach (mcnt[i]) mcnt[i] = 0;
                while (expq.size() > 0 && expq[expq.size()-1].due > cyc)
                    void'(expq.pop_back());
            end else begin
                if (eo && ov) begin
                    mcnt[op] = mcnt[op] - 1;
                    expq.push_back('{due: cyc + PD, prt: op});
                end
                if (ep && pv) mcnt[pp] = mcnt[pp] + 1;
                if (bus.buf_ready) mrun = 1'b1;
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.buf_ready = 1'b0;
        drive(0, 0, 0, 0, 0);
        tick();
        tick();
        rst = 1'b0;
        repeat (5) begin
            drive(1, $urandom_range(0, 7), 1, 1, $urandom_range(0, 7));
            #3;
            chk("wait_push_rdy", bus.in_push_rdy, 0);
            chk("wait_pop_rdy", bus.in_pop_rdy, 0);
            tick();
        end
        bus.buf_ready = 1'b1;
        drive(0, 3, 0, 1, 3);
        #3;
        chk("first_ready_push_rdy", bus.in_push_rdy, 0);
        tick();
        #3;
        chk("run_push_rdy", bus.in_push_rdy, 1);
        chk("run_pop_empty", bus.in_pop_rdy, 0);
        chk("run_empty", bus.empty, 8'hFF);
        tick();

        for (int i = 0; i < 4; i++) begin
            drive(1, 3, 10 + i, 0, 0);
            #3;
            chk("fill_push", bus.push, 1);
            chk("fill_din", bus.pu_din, 10 + i);
            tick();
        end
        drive(1, 3, 14, 0, 0);
        #3;
        chk("full3", bus.full[3], 1);
        chk("full3_rdy", bus.in_push_rdy, 0);
        chk("full3_push", bus.push, 0);
        tick();
        drive(1, 3, 5, 1, 3);
        #3;
        chk("both3_pop_rdy", bus.in_pop_rdy, 1);
        chk("both3_push_rdy", bus.in_push_rdy, 0);
        tick();
        drive(1, 3, 5, 0, 0);
        #3;
        chk("refill3_rdy", bus.in_push_rdy, 1);
        chk("refill3_full", bus.full[3], 0);
        tick();
        drive(0, 0, 0, 0, 0);
        #3;
        chk("refill3_full_after", bus.full[3], 1);
        tick();

        drive(1, 2, 7, 0, 0);
        tick();
        drive(1, 2, 8, 1, 2);
        #3;
        chk("both2_push_rdy", bus.in_push_rdy, 1);
        chk("both2_pop_rdy", bus.in_pop_rdy, 1);
        tick();
        drive(0, 0, 0, 0, 0);
        #3;
        chk("both2_empty", bus.empty[2], 0);
        tick();

        drive(1, 1, 1, 0, 0); tick();
        drive(1, 1, 2, 0, 0); tick();
        drive(1, 5, 3, 0, 0); tick();
        drive(0, 0, 0, 1, 1); tick();
        drive(0, 0, 0, 1, 5); tick();
        drive(0, 0, 0, 1, 1); tick();
        drive(0, 0, 0, 0, 0);
        repeat (PD + 2) tick();

        drive(1, 4, 9, 0, 0); tick();
        drive(0, 0, 0, 1, 4); tick();
        drive(0, 0, 0, 0, 0);
        rst = 1'b1;
        bus.buf_ready = 1'b0;
        tick();
        rst = 1'b0;
        repeat (3) begin
            drive(1, 0, 1, 1, 3);
            #3;
            chk("rst_rsp_vld", bus.rsp_vld, 0);
            chk("rst_empty", bus.empty, 8'hFF);
            chk("rst_push_rdy", bus.in_push_rdy, 0);
            tick();
        end
        bus.buf_ready = 1'b1;
        tick();

        for (int n = 0; n < 600; n++) begin
            int lim;
            lim = (n < 300) ? 3 : 7;
            bus.buf_ready = ($urandom_range(0, 9) != 0);
            rst = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 9) < 7, $urandom_range(0, lim), $urandom_range(0, 15),
                  $urandom_range(0, 9) < 6, $urandom_range(0, lim));
            tick();
        end

        rst = 1'b0;
        bus.buf_ready = 1'b1;
        drive(0, 0, 0, 0, 0);
        repeat (PD + 3) tick();
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL rsp_drain: got %0d pending want 0", expq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
